// File: rtl/spike_window_classifier.sv
// Windowed spike-count readout: accumulates per-class spikes over WINDOW_LEN cycles,
// scans for the argmax and pulses valid_o. Optional tie flag: SNN_CLASSIFIER_TIE_FLAG_EN.
module spike_window_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH_P     = 8,
    parameter int WINDOW_LEN  = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic [NUM_CLASSES-1:0]         spike_i,
    output logic [$clog2(NUM_CLASSES)-1:0] class_o,
    output logic [WIDTH_P-1:0]             max_count_o,
    output logic                           valid_o,
    output logic                           busy_o
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
    ,
    output logic                           tie_o
`endif
);

    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam int TMR_W = $clog2(WINDOW_LEN);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [TMR_W-1:0]   LAST_TMR = TMR_W'(WINDOW_LEN - 1);
    localparam logic [WIDTH_P-1:0] CNT_MAX  = {WIDTH_P{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        SCAN   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH_P-1:0]   cnt_r [NUM_CLASSES];
    logic [TMR_W-1:0]     timer_r;
    logic [IDX_W-1:0]     idx_r;
    logic [WIDTH_P-1:0]   best_cnt_r;
    logic [IDX_W-1:0]     best_idx_r;
    logic [IDX_W-1:0]     class_r;
    logic [WIDTH_P-1:0]   max_count_r;
    logic                 valid_r;

    logic [WIDTH_P-1:0]   scan_cnt_s;
    logic                 win_s;
    logic [WIDTH_P-1:0]   best_cnt_nxt_s;
    logic [IDX_W-1:0]     best_idx_nxt_s;

`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
    logic                 tie_track_r;
    logic                 tie_r;
    logic                 tie_nxt_s;
`endif

    // Next-state decode; dropping en_i in ACCUM or SCAN abandons the window.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_i) state_nxt_s = ACCUM;
                else      state_nxt_s = IDLE;
            end
            ACCUM: begin
                if (!en_i)                  state_nxt_s = IDLE;
                else if (timer_r == LAST_TMR) state_nxt_s = SCAN;
                else                        state_nxt_s = ACCUM;
            end
            SCAN: begin
                if (!en_i)                state_nxt_s = IDLE;
                else if (idx_r == LAST_IDX) state_nxt_s = REPORT;
                else                      state_nxt_s = SCAN;
            end
            REPORT: begin
                if (en_i) state_nxt_s = ACCUM;
                else      state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequential argmax step: strict compare keeps the lowest index on ties.
    always_comb begin
        scan_cnt_s     = cnt_r[idx_r];
        win_s          = (scan_cnt_s > best_cnt_r);
        best_cnt_nxt_s = best_cnt_r;
        best_idx_nxt_s = best_idx_r;
        if (win_s) begin
            best_cnt_nxt_s = scan_cnt_s;
            best_idx_nxt_s = idx_r;
        end else begin
            best_cnt_nxt_s = best_cnt_r;
            best_idx_nxt_s = best_idx_r;
        end
    end

`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
    // Tie tracking: another class matches the current best; a strict win clears it.
    always_comb begin
        tie_nxt_s = tie_track_r;
        if (win_s) begin
            tie_nxt_s = 1'b0;
        end else if ((scan_cnt_s == best_cnt_r) && (idx_r != best_idx_r)) begin
            tie_nxt_s = 1'b1;
        end else begin
            tie_nxt_s = tie_track_r;
        end
    end
`endif

    // State, counters, scan registers and registered result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            timer_r     <= '0;
            idx_r       <= '0;
            best_cnt_r  <= '0;
            best_idx_r  <= '0;
            class_r     <= '0;
            max_count_r <= '0;
            valid_r     <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
            tie_track_r <= 1'b0;
            tie_r       <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            valid_r <= 1'b0;
            case (state_r)
                ACCUM: begin
                    if (en_i) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            if (spike_i[i] && (cnt_r[i] != CNT_MAX)) begin
                                cnt_r[i] <= cnt_r[i] + WIDTH_P'(1);
                            end
                        end
                        if (timer_r == LAST_TMR) begin
                            timer_r    <= '0;
                            idx_r      <= '0;
                            best_cnt_r <= '0;
                            best_idx_r <= '0;
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
                            tie_track_r <= 1'b0;
`endif
                        end else begin
                            timer_r <= timer_r + TMR_W'(1);
                        end
                    end else begin
                        timer_r <= '0;
                        for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
                    end
                end
                SCAN: begin
                    if (en_i) begin
                        best_cnt_r <= best_cnt_nxt_s;
                        best_idx_r <= best_idx_nxt_s;
                        idx_r      <= idx_r + IDX_W'(1);
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
                        tie_track_r <= tie_nxt_s;
`endif
                        if (idx_r == LAST_IDX) begin
                            class_r     <= best_idx_nxt_s;
                            max_count_r <= best_cnt_nxt_s;
                            valid_r     <= 1'b1;
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
                            tie_r       <= tie_nxt_s;
`endif
                        end
                    end else begin
                        idx_r <= '0;
                        for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
                    end
                end
                REPORT: begin
                    timer_r <= '0;
                    for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
                end
                IDLE: begin
                    timer_r <= '0;
                    for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
                end
                default: begin
                    timer_r <= '0;
                    for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
                end
            endcase
        end
    end

    assign class_o     = class_r;
    assign max_count_o = max_count_r;
    assign valid_o     = valid_r;
    assign busy_o      = (state_r != IDLE);
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
    assign tie_o       = tie_r;
`endif

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed, table-driven bench for spike_window_classifier (default and 4-bit-counter instances).
module tb_spike_window_classifier;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] spike;

    logic [3:0] class_a;
    logic [7:0] max_a;
    logic       valid_a;
    logic       busy_a;
    logic [3:0] class_b;
    logic [3:0] max_b;
    logic       valid_b;
    logic       busy_b;
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
    logic       tie_a;
    logic       tie_b;
`endif

    int tests  = 0;
    int failed = 0;

    spike_window_classifier #(.NUM_CLASSES(10), .WIDTH_P(8), .WINDOW_LEN(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .spike_i(spike),
        .class_o(class_a), .max_count_o(max_a), .valid_o(valid_a), .busy_o(busy_a)
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
        , .tie_o(tie_a)
`endif
    );

    spike_window_classifier #(.NUM_CLASSES(10), .WIDTH_P(4), .WINDOW_LEN(64)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .spike_i(spike),
        .class_o(class_b), .max_count_o(max_b), .valid_o(valid_b), .busy_o(busy_b)
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
        , .tie_o(tie_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0][6:0] cnts;      // spikes per class in the window (first N cycles)
        logic            scan_ones; // drive all-ones during SCAN/REPORT
        int              exp_class;
        int              exp_max;
        int              exp_tie;
        int              exp_class4;
        int              exp_max4;
    } rec_t;

    rec_t vec [10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives one full window (64 ACCUM + 10 SCAN + 1 REPORT) starting the
    // negedge after the DUT entered ACCUM; returns pulse statistics.
    task automatic run_window(input rec_t r, output int pulses, output int pulse_cyc,
                              output int busy_low, output int valid_b_last);
        logic [9:0] p;
        pulses = 0; pulse_cyc = 0; busy_low = 0; valid_b_last = 0;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            if (valid_a) begin
                pulses++;
                pulse_cyc = c + 1;
            end
            if (!busy_a) busy_low++;
            if (c == 74) valid_b_last = int'(valid_b);
            if (c < 64) begin
                for (int i = 0; i < 10; i++) p[i] = (c < int'(r.cnts[i]));
            end else begin
                p = r.scan_ones ? 10'h3FF : 10'h000;
            end
            spike = p;
        end
    endtask

    initial begin
        int pulses, pcyc, blow, vb;
        vec[0] = '0; vec[0].cnts[3] = 7'd64;
        vec[0].exp_class = 3; vec[0].exp_max = 64; vec[0].exp_tie = 0; vec[0].exp_class4 = 3; vec[0].exp_max4 = 15;
        vec[1] = '0; vec[1].cnts[2] = 7'd10; vec[1].cnts[7] = 7'd10; vec[1].cnts[9] = 7'd9;
        vec[1].exp_class = 2; vec[1].exp_max = 10; vec[1].exp_tie = 1; vec[1].exp_class4 = 2; vec[1].exp_max4 = 10;
        vec[2] = '0; vec[2].cnts[2] = 7'd10; vec[2].cnts[7] = 7'd11; vec[2].cnts[9] = 7'd9;
        vec[2].exp_class = 7; vec[2].exp_max = 11; vec[2].exp_tie = 0; vec[2].exp_class4 = 7; vec[2].exp_max4 = 11;
        vec[3] = '0; vec[3].cnts[5] = 7'd64;
        vec[3].exp_class = 5; vec[3].exp_max = 64; vec[3].exp_tie = 0; vec[3].exp_class4 = 5; vec[3].exp_max4 = 15;
        vec[4] = '0; vec[4].scan_ones = 1'b1;
        vec[4].exp_class = 0; vec[4].exp_max = 0; vec[4].exp_tie = 1; vec[4].exp_class4 = 0; vec[4].exp_max4 = 0;
        vec[5] = vec[4];
        vec[6] = '0; vec[6].cnts[9] = 7'd1;
        vec[6].exp_class = 9; vec[6].exp_max = 1; vec[6].exp_tie = 0; vec[6].exp_class4 = 9; vec[6].exp_max4 = 1;
        vec[7] = '0; vec[7].cnts[0] = 7'd64; vec[7].cnts[9] = 7'd64;
        vec[7].exp_class = 0; vec[7].exp_max = 64; vec[7].exp_tie = 1; vec[7].exp_class4 = 0; vec[7].exp_max4 = 15;
        vec[8] = '0; vec[8].cnts[0] = 7'd32; vec[8].cnts[4] = 7'd33; vec[8].cnts[5] = 7'd32;
        vec[8].exp_class = 4; vec[8].exp_max = 33; vec[8].exp_tie = 0; vec[8].exp_class4 = 0; vec[8].exp_max4 = 15;
        vec[9] = '0; vec[9].cnts[8] = 7'd20; vec[9].cnts[1] = 7'd16;
        vec[9].exp_class = 8; vec[9].exp_max = 20; vec[9].exp_tie = 0; vec[9].exp_class4 = 1; vec[9].exp_max4 = 15;

        rst_n = 1'b0; en = 1'b0; spike = 10'h000;
        repeat (3) @(negedge clk);
        chk("reset_class", int'(class_a), 0);
        chk("reset_max", int'(max_a), 0);
        chk("reset_valid", int'(valid_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy_a), 0);
        en = 1'b1;

        // Back-to-back windows with en_i held high.
        for (int k = 0; k < 10; k++) begin
            run_window(vec[k], pulses, pcyc, blow, vb);
            chk($sformatf("v%0d_pulses", k), pulses, 1);
            chk($sformatf("v%0d_latency", k), pcyc, 75);
            chk($sformatf("v%0d_busy_low", k), blow, 0);
            chk($sformatf("v%0d_class", k), int'(class_a), vec[k].exp_class);
            chk($sformatf("v%0d_max", k), int'(max_a), vec[k].exp_max);
            chk($sformatf("v%0d_valid_w4", k), vb, 1);
            chk($sformatf("v%0d_class_w4", k), int'(class_b), vec[k].exp_class4);
            chk($sformatf("v%0d_max_w4", k), int'(max_b), vec[k].exp_max4);
`ifdef SNN_CLASSIFIER_TIE_FLAG_EN
            chk($sformatf("v%0d_tie", k), int'(tie_a), vec[k].exp_tie);
`endif
        end

        // Abort: drop en_i on the 30th ACCUM cycle of the next window.
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (valid_a) pulses++;
            spike = 10'h3FF;
            if (c == 29) en = 1'b0;
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (valid_a) pulses++;
            spike = 10'h000;
        end
        chk("abort_no_valid", pulses, 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_hold_class", int'(class_a), 8);
        chk("abort_hold_max", int'(max_a), 20);
        chk("abort_hold_class_w4", int'(class_b), 1);
        chk("abort_hold_max_w4", int'(max_b), 15);
        en = 1'b1;
        begin
            rec_t r;
            r = '0; r.cnts[1] = 7'd5;
            run_window(r, pulses, pcyc, blow, vb);
        end
        chk("reen_pulses", pulses, 1);
        chk("reen_latency", pcyc, 75);
        chk("reen_class", int'(class_a), 1);
        chk("reen_max", int'(max_a), 5);
        chk("reen_max_w4", int'(max_b), 5);

        // Asynchronous reset in the middle of ACCUM.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            spike = 10'h3FF;
        end
        chk("midacc_busy", int'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_class", int'(class_a), 0);
        chk("arst_max", int'(max_a), 0);
        chk("arst_valid", int'(valid_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_busy_w4", int'(busy_b), 0);
        en = 1'b0;
        spike = 10'h000;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (valid_a) pulses++;
        end
        chk("post_rst_busy", int'(busy_a), 0);
        chk("post_rst_no_valid", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Readout stage that sits directly downstream of the output LIF layer and consumes its NUM_CLASSES-wide spike vector.
- Counts spikes per class over a fixed window of WINDOW_LEN cycles, then scans the counts sequentially to find the argmax.
- Reports the winning class index and its count with a one-cycle valid pulse.
- Replaces free-running per-class counters with a windowed, self-clearing decision.

Parameters:
- NUM_CLASSES, 10, number of output neurons / classes (>=2).
- WIDTH_P, 8, per-class spike counter width (saturating).
- WINDOW_LEN, 64, accumulation window length in cycles (>=2).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous reset, active low.
- en_i  input  1  run enable; low aborts any window in progress.
- spike_i  input  NUM_CLASSES  output-layer spike vector, bit i = class i.
- class_o  output  $clog2(NUM_CLASSES)  winning class index of last completed window.
- max_count_o  output  WIDTH_P  spike count of the winning class.
- valid_o  output  1  one-cycle pulse: class_o/max_count_o updated this cycle.
- busy_o  output  1  high in ACCUM, SCAN, REPORT.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; all counters, timer, scan index, best registers = 0; class_o=0, max_count_o=0, valid_o=0, busy_o=0.
- FSM states: IDLE, ACCUM, SCAN, REPORT. All registers clock on posedge clk_i.
- IDLE: counters held at 0. If en_i=1, go to ACCUM with timer=0.
- ACCUM, every cycle:
  - count[i] += spike_i[i]; saturates at 2^WIDTH_P-1 with no wrap.
  - timer increments.
  - When timer==WINDOW_LEN-1, that cycle's spikes are still counted; next state is SCAN with idx=0, best_cnt=0, best_idx=0.
  - Exactly WINDOW_LEN sample cycles are counted per window.
- SCAN: one class per cycle.
  - If count[idx] > best_cnt (strict), load best_cnt/best_idx. Ties therefore resolve to the lowest index.
  - After idx==NUM_CLASSES-1 is evaluated, go to REPORT.
  - spike_i is ignored.
- REPORT: one cycle.
  - class_o=best_idx and max_count_o=best_cnt are registered and become visible in this cycle.
  - valid_o=1 this cycle only.
  - All counters clear.
  - spike_i is ignored.
  - Next state is ACCUM (timer=0) if en_i=1, else IDLE.
- Latency: the valid_o cycle is NUM_CLASSES+1 cycles after the last ACCUM cycle. The back-to-back window period is WINDOW_LEN+NUM_CLASSES+1 cycles.
- class_o and max_count_o hold their values between REPORT cycles. They are not cleared by an abort.
- en_i=0 during ACCUM or SCAN: next state IDLE, counters cleared, no valid_o, outputs keep their previous result.
- All-zero window: class_o=0, max_count_o=0, valid_o still pulses.
- Async reset mid-operation returns to reset values immediately, with no partial report.
- busy_o = (state != IDLE), decoded from the state register.

Optional Feature:
- Macro: SNN_CLASSIFIER_TIE_FLAG_EN.
- With the macro:
  - Adds output port tie_o (1 bit), reset 0.
  - During SCAN, track whether any class with count == best_cnt exists besides best_idx. The flag is cleared whenever best is updated by a strict win.
  - tie_o is registered with class_o in REPORT and held until the next REPORT.
  - tie_o=1 for an all-zero window when NUM_CLASSES>=2.
- Without the macro: tie_o port and its tracking logic are absent; ties resolve silently to the lowest index.

Test Plan:
1. Reset with rst_ni=0 while in ACCUM -> class_o=0, max_count_o=0, valid_o=0, busy_o=0 immediately; after release, state IDLE.
2. Defaults, en_i=1, spike_i=10'b0000001000 every cycle -> valid_o pulse exactly 75 cycles after the first ACCUM cycle (counting that cycle as 1), class_o=3, max_count_o=64, valid_o high for exactly 1 cycle.
3. Bits 2 and 7 each spike 10 times, bit 9 spikes 9 times in one window -> class_o=2, max_count_o=10; with SNN_CLASSIFIER_TIE_FLAG_EN, tie_o=1. Repeat with bit 7 spiking 11 times -> class_o=7, tie_o=0.
4. WIDTH_P=4, bit 5 spikes all 64 cycles -> max_count_o=15 (saturated, no wrap), class_o=5.
5. Abort: result A reported, then drop en_i at cycle 30 of the next window -> no valid_o, class_o/max_count_o still A; re-enable with bit 1 spiking 5 times -> class_o=1, max_count_o=5 (no carry-over from the aborted window).
6. Back-to-back with en_i held: spike_i=all-ones during SCAN/REPORT only and zero in ACCUM -> every report gives class_o=0, max_count_o=0; reports spaced 75 cycles apart.
